// File: rtl/audio_frame_packer_if.sv
// audio_frame_packer_if: sample-set input strobe and byte-stream output handshake
//   sample_valid/sample_data : one-cycle strobe and CH_NUM*SAMPLE_W set, channel 0 in LSBs
//   out_data/out_valid/out_last : packet byte stream, out_last on final payload byte
//   out_ready                 : sink accepts the byte on out_valid && out_ready
//   master = source/sink side, slave = packer side
interface audio_frame_packer_if #(
  parameter int CH_NUM   = 2,
  parameter int SAMPLE_W = 16
);
  logic                       sample_valid;
  logic [CH_NUM*SAMPLE_W-1:0] sample_data;
  logic [7:0]                 out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_last;
  modport master (output sample_valid, sample_data, out_ready, input out_data, out_valid, out_last);
  modport slave (input sample_valid, sample_data, out_ready, output out_data, out_valid, out_last);
endinterface

// File: rtl/audio_frame_packer.sv
// audio_frame_packer: buffers audio sample sets and emits them as framed byte packets
//   sys_clk, rst : clock, asynchronous active-high reset
//   enable       : permits new packet starts
//   bus          : sample input and byte-stream output (slave modport)
//   pkt_len      : constant packet length in bytes
//   fifo_level   : buffered sample-set count
//   overflow     : sticky, set when a sample set is dropped on a full buffer
module audio_frame_packer #(
  parameter int CH_NUM        = 2,
  parameter int SAMPLE_W      = 16,
  parameter int FRAME_SAMPLES = 256,
  parameter int DEPTH         = 1024
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   enable,
  audio_frame_packer_if.slave    bus,
  output logic [15:0]            pkt_len,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow
);
  localparam int SW  = CH_NUM * SAMPLE_W;
  localparam int BW  = SAMPLE_W / 8;
  localparam int AW  = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int LW  = $clog2(DEPTH) + 1;
  localparam int BCW = BW > 1 ? $clog2(BW) : 1;
  localparam int CCW = CH_NUM > 1 ? $clog2(CH_NUM) : 1;
  localparam int SCW = FRAME_SAMPLES > 1 ? $clog2(FRAME_SAMPLES) : 1;
  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;
  state_t         state_q, state_d;
  logic [SW-1:0]  mem [DEPTH];
  logic [SW-1:0]  set_q, set_d;
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [LW-1:0]  level_q;
  logic [2:0]     hcnt_q, hcnt_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [CCW-1:0] ccnt_q, ccnt_d;
  logic [SCW-1:0] scnt_q, scnt_d;
  logic [15:0]    seq_q, seq_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d, last_q, last_d, ovf_q;
  logic           wr, pop, acc, b_end, c_end;
  // byte b of channel c, b = 0 being the sample's MSB byte
  function automatic logic [7:0] pick(logic [SW-1:0] s, logic [CCW-1:0] c, logic [BCW-1:0] b);
    return 8'(s >> (int'(c) * SAMPLE_W + SAMPLE_W - 8 - 8 * int'(b)));
  endfunction
  assign wr    = bus.sample_valid && level_q != LW'(DEPTH);
  assign acc   = valid_q && bus.out_ready;
  assign b_end = bcnt_q == BCW'(BW - 1);
  assign c_end = ccnt_q == CCW'(CH_NUM - 1);
  // the next byte is always prepared combinationally so the output register never bubbles
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bcnt_d  = bcnt_q;
    ccnt_d  = ccnt_q;
    scnt_d  = scnt_q;
    set_d   = set_q;
    data_d  = data_q;
    valid_d = valid_q;
    seq_d   = seq_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (enable && level_q >= LW'(FRAME_SAMPLES)) begin
        state_d = HDR;
        hcnt_d  = '0;
        data_d  = 8'hA5;
        valid_d = 1'b1;
      end
      HDR: if (acc) begin
        hcnt_d = hcnt_q + 3'd1;
        data_d = hcnt_d == 3'd1 ? 8'h5A : hcnt_d == 3'd2 ? seq_q[15:8] : hcnt_d == 3'd3 ? seq_q[7:0] :
                 hcnt_d == 3'd4 ? 8'(CH_NUM) : 8'(SAMPLE_W);
        if (hcnt_q == 3'd5) begin
          state_d = PAY;
          pop     = 1'b1;
          set_d   = mem[rptr_q];
          bcnt_d  = '0;
          ccnt_d  = '0;
          scnt_d  = '0;
          data_d  = pick(set_d, ccnt_d, bcnt_d);
        end
      end
      PAY: if (acc) begin
        if (last_q) begin
          state_d = IDLE;
          valid_d = 1'b0;
          data_d  = 8'h00;
          seq_d   = seq_q + 16'd1;
        end else begin
          bcnt_d = b_end ? '0 : bcnt_q + 1'b1;
          ccnt_d = !b_end ? ccnt_q : c_end ? '0 : ccnt_q + 1'b1;
          if (b_end && c_end) begin
            scnt_d = scnt_q + 1'b1;
            pop    = 1'b1;
            set_d  = mem[rptr_q];
          end
          data_d = pick(set_d, ccnt_d, bcnt_d);
        end
      end
      default: state_d = IDLE;
    endcase
    last_d = state_d == PAY && scnt_d == SCW'(FRAME_SAMPLES - 1) && ccnt_d == CCW'(CH_NUM - 1) &&
             bcnt_d == BCW'(BW - 1);
  end
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      bcnt_q  <= '0;
      ccnt_q  <= '0;
      scnt_q  <= '0;
      set_q   <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      seq_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bcnt_q  <= bcnt_d;
      ccnt_q  <= ccnt_d;
      scnt_q  <= scnt_d;
      set_q   <= set_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      seq_q   <= seq_d;
      wptr_q  <= !wr ? wptr_q : wptr_q == AW'(DEPTH - 1) ? '0 : wptr_q + 1'b1;
      rptr_q  <= !pop ? rptr_q : rptr_q == AW'(DEPTH - 1) ? '0 : rptr_q + 1'b1;
      level_q <= level_q + LW'(wr) - LW'(pop);
      ovf_q   <= ovf_q | (bus.sample_valid & ~wr);
    end
  always_ff @(posedge sys_clk)
    if (wr) mem[wptr_q] <= bus.sample_data;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign pkt_len       = 16'(6 + FRAME_SAMPLES * CH_NUM * SAMPLE_W / 8);
  assign fifo_level    = level_q;
  assign overflow      = ovf_q;
endmodule

// File: tb/tb_audio_frame_packer.sv
// tb_audio_frame_packer: scoreboard bench with a packet-level reference model
module tb_audio_frame_packer;
  localparam int CH = 2, SW = 16, F = 2, D = 4, BW = SW / 8, PL = 6 + F * CH * BW;
  typedef struct packed {logic [7:0] d; logic l;} exp_t;
  logic sys_clk = 1'b0, rst = 1'b1, enable = 1'b0, overflow;
  logic [15:0] pkt_len;
  logic [$clog2(D):0] fifo_level;
  exp_t exp_q[$];
  logic [CH*SW-1:0] pend[$];
  logic [15:0] seq_m = 16'h0;
  int checks = 0, errors = 0, acc_n = 0, done_n = 0, cyc = 0, pkt_bytes = 0;
  int rise_cyc = 0, last_cyc = -1, rmode = 0;
  bit prev_v = 0, stall_v = 0, all_rdy = 0, gap_chk = 0;
  logic [7:0] st_d;
  logic st_l;

  audio_frame_packer_if #(.CH_NUM(CH), .SAMPLE_W(SW)) bus ();
  audio_frame_packer #(.CH_NUM(CH), .SAMPLE_W(SW), .FRAME_SAMPLES(F), .DEPTH(D)) dut (
    .sys_clk(sys_clk), .rst(rst), .enable(enable), .bus(bus),
    .pkt_len(pkt_len), .fifo_level(fifo_level), .overflow(overflow));

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, got, want);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // one packet: header with the packet's sequence number, then F sets channel-0 first, MSB byte first
  task automatic pack();
    int n = F * CH * BW, k = 0;
    logic [SW-1:0] smp;
    exp_q.push_back({8'hA5, 1'b0});
    exp_q.push_back({8'h5A, 1'b0});
    exp_q.push_back({seq_m[15:8], 1'b0});
    exp_q.push_back({seq_m[7:0], 1'b0});
    exp_q.push_back({8'(CH), 1'b0});
    exp_q.push_back({8'(SW), 1'b0});
    foreach (pend[i])
      for (int c = 0; c < CH; c++) begin
        smp = pend[i][c*SW +: SW];
        for (int b = BW - 1; b >= 0; b--) begin
          k++;
          exp_q.push_back({smp[8*b +: 8], k == n});
        end
      end
    pend.delete();
    seq_m++;
  endtask

  // a set is kept while the buffer (upper bound: accepted minus sets of finished packets) has room
  task automatic put(input logic [CH*SW-1:0] s);
    bus.sample_valid = 1'b1;
    bus.sample_data  = s;
    if (acc_n - F * done_n < D) begin
      acc_n++;
      pend.push_back(s);
      if (pend.size() == F) pack();
    end
    step();
    bus.sample_valid = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    pend.delete();
    seq_m  = 16'h0;
    acc_n  = 0;
    done_n = 0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_bytes(input int nb, input int budget);
    int n = 0;
    while (pkt_bytes < nb && n < budget) begin
      step();
      n++;
    end
    chk("wait_bytes_timeout", pkt_bytes >= nb, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_last"}, bus.out_last, 0);
    chk({tag, "_data"}, bus.out_data, 0);
    chk({tag, "_level"}, fifo_level, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge sys_clk);
      #1;
      bus.out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? ~bus.out_ready : 1'($urandom_range(0, 1));
    end
  end

  // monitor: pops the scoreboard on every accepted byte, checks stall stability and timing
  always @(negedge sys_clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      pkt_bytes = 0;
      stall_v   = 0;
      prev_v    = 0;
    end else begin
      if (stall_v) chk("stall_hold", {bus.out_valid, bus.out_last, bus.out_data}, {1'b1, st_l, st_d});
      if (bus.out_valid && !prev_v) begin
        if (gap_chk && last_cyc >= 0) chk("idle_gap", cyc - last_cyc, 2);
        rise_cyc = cyc;
        all_rdy  = 1;
      end
      if (bus.out_valid) all_rdy &= bus.out_ready;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte got %02h want none", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          chk("byte", bus.out_data, e.d);
          chk("last", bus.out_last, e.l);
        end
        pkt_bytes++;
        if (bus.out_last) begin
          if (all_rdy) chk("no_bubble", cyc - rise_cyc, PL - 1);
          last_cyc  = cyc;
          done_n++;
          pkt_bytes = 0;
        end
      end
      stall_v = bus.out_valid && !bus.out_ready;
      st_d    = bus.out_data;
      st_l    = bus.out_last;
      prev_v  = bus.out_valid;
    end
  end

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    repeat (2) @(negedge sys_clk);
    check_reset_outputs("por");
    chk("pkt_len", pkt_len, PL);
    step();
    rst = 1'b0;
    // basic packet with ready held high
    enable = 1'b1;
    put(32'h1111_2222);
    put(32'h3333_4444);
    drain(200);
    // ready toggling every cycle
    rmode = 1;
    put(32'h5555_6666);
    put(32'h7777_8888);
    drain(200);
    rmode = 0;
    // overflow with enable low, from a fresh reset so seq starts at 0
    step();
    rst = 1'b1;
    model_reset();
    @(negedge sys_clk);
    check_reset_outputs("rst2");
    step();
    rst = 1'b0;
    enable = 1'b0;
    repeat (6) put($urandom);
    step();
    chk("full_level", fifo_level, D);
    chk("overflow_set", overflow, 1);
    enable = 1'b1;
    drain(300);
    repeat (3) step();
    chk("level_empty", fifo_level, 0);
    chk("overflow_sticky", overflow, 1);
    // enable dropped inside the header: packet completes, no new start
    put($urandom);
    put($urandom);
    wait_bytes(3, 100);
    enable = 1'b0;
    put($urandom);
    put($urandom);
    repeat (60) step();
    chk("no_restart", exp_q.size(), PL);
    chk("held_level", fifo_level, 2);
    enable = 1'b1;
    drain(200);
    // asynchronous reset in the middle of the payload
    put($urandom);
    put($urandom);
    wait_bytes(8, 100);
    #2;
    rst = 1'b1;
    model_reset();
    @(negedge sys_clk);
    check_reset_outputs("rst_mid");
    step();
    rst = 1'b0;
    put($urandom);
    put($urandom);
    drain(200);
    // sequence wrap, back-to-back packets separated by one idle cycle
    repeat (2) step();
    force dut.seq_q = 16'hFFFF;
    step();
    step();
    release dut.seq_q;
    seq_m    = 16'hFFFF;
    last_cyc = -1;
    gap_chk  = 1;
    repeat (4) put($urandom);
    drain(300);
    gap_chk = 0;
    // random traffic with random back-pressure and enable
    rmode = 2;
    for (int i = 0; i < 400; i++) begin
      enable = $urandom_range(0, 7) != 0;
      if ($urandom_range(0, 2) == 0 && acc_n - F * done_n < D) put($urandom);
      else step();
    end
    enable = 1'b1;
    for (int i = 0; i < 500 && pend.size() != 0; i++)
      if (acc_n - F * done_n < D) put($urandom);
      else step();
    chk("pend_flushed", pend.size(), 0);
    drain(3000);
    repeat (3) step();
    chk("final_level", fifo_level, 0);
    chk("final_ovf", overflow, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
